// File: rtl/register_bank_pkg.sv
// Shared CPU datapath definitions for the architectural register file.
//   REG_W     : register / data width
//   REG_CNT   : number of architectural registers
//   reg_idx_t : register index type
//   R0..R7    : named register indices
package register_bank_pkg;

    localparam int unsigned REG_W   = 8;
    localparam int unsigned REG_CNT = 8;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t R0 = 3'd0;
    localparam reg_idx_t R1 = 3'd1;
    localparam reg_idx_t R2 = 3'd2;
    localparam reg_idx_t R3 = 3'd3;
    localparam reg_idx_t R4 = 3'd4;
    localparam reg_idx_t R5 = 3'd5;
    localparam reg_idx_t R6 = 3'd6;
    localparam reg_idx_t R7 = 3'd7;

endpackage : register_bank_pkg

// File: rtl/reg_cell.sv
// Single WIDTH-bit storage register with load enable.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q to 0
//   load  : when high, q takes d on the rising edge
//   d     : next value
//   q     : stored value
module reg_cell #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : reg_cell

// File: rtl/register_bank.sv
// General-purpose register file R0..R(DEPTH-1) for the 8-bit CPU datapath.
// One write port and one combinational read port share a single select.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears every register
//   data_in  : write data
//   reg_sel  : register index for both write and read
//   en       : write enable, active-high
//   data_out : contents of the selected register (no write-through bypass)
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned WIDTH = REG_W,
    parameter int unsigned DEPTH = REG_CNT,
    parameter int unsigned SEL_W = $clog2(REG_CNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0] reg_sel,
    input  logic             en,
    output logic [WIDTH-1:0] data_out
);

    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] cell_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        // One-hot write decode: only the selected cell loads.
        assign load[i] = en && (reg_sel == SEL_W'(i));

        reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .d     (data_in),
            .q     (cell_q[i])
        );
    end

    // DEPTH:1 read mux; reads the registered value, so a write only shows after the edge.
    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reg_sel == SEL_W'(i)) begin
                data_out = cell_q[i];
            end
        end
    end

endmodule : register_bank

// File: tb/tb_register_bank.sv
module tb_register_bank;
    import register_bank_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    reg_idx_t   reg_sel;
    logic       en;
    logic [7:0] data_out;

    int compared;
    int mismatched;

    register_bank #(
        .WIDTH (8),
        .DEPTH (8),
        .SEL_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .reg_sel  (reg_sel),
        .en       (en),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // Stimulus-only helper: one write on the next rising edge, leaves en asserted.
    task automatic do_write(input reg_idx_t idx, input logic [7:0] val);
        @(negedge clk);
        reg_sel = idx;
        data_in = val;
        en      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        en      = 1'b1;
        data_in = 8'hFF;
        reg_sel = R0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (data_out !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_hold: got %h required %h", data_out, 8'h00);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reg_sel = reg_idx_t'(i);
            #1;
            compared++;
            if (data_out !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_sweep R%0d: got %h required %h", i, data_out, 8'h00);
            end
        end
    endtask

    task automatic test_basic_writes;
        logic [7:0] expv [8];
        expv = '{8'hAA, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'hFF};
        do_write(R0, 8'hAA);
        do_write(R3, 8'h55);
        do_write(R7, 8'hFF);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            reg_sel = reg_idx_t'(i);
            #1;
            compared++;
            if (data_out !== expv[i]) begin
                mismatched++;
                $display("FAIL basic_write R%0d: got %h required %h", i, data_out, expv[i]);
            end
        end
    endtask

    task automatic test_write_gating;
        @(negedge clk);
        en      = 1'b0;
        data_in = 8'h12;
        reg_sel = R3;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            compared++;
            if (data_out !== 8'h55) begin
                mismatched++;
                $display("FAIL write_gating edge%0d: got %h required %h", k, data_out, 8'h55);
            end
        end
    endtask

    task automatic test_no_bypass;
        @(negedge clk);
        reg_sel = R5;
        data_in = 8'h3C;
        en      = 1'b1;
        #1;
        compared++;
        if (data_out !== 8'h00) begin
            mismatched++;
            $display("FAIL no_bypass_before: got %h required %h", data_out, 8'h00);
        end
        @(posedge clk);
        #1;
        compared++;
        if (data_out !== 8'h3C) begin
            mismatched++;
            $display("FAIL no_bypass_after: got %h required %h", data_out, 8'h3C);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 8; i++) begin
            do_write(reg_idx_t'(i), 8'(i * 8'h11));
        end
        @(negedge clk);
        en      = 1'b0;
        reg_sel = R6;
        #1;
        compared++;
        if (data_out !== 8'h66) begin
            mismatched++;
            $display("FAIL preload_R6: got %h required %h", data_out, 8'h66);
        end
        // Pulse reset well away from any rising edge.
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (data_out !== 8'h00) begin
            mismatched++;
            $display("FAIL async_reset_immediate: got %h required %h", data_out, 8'h00);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reg_sel = reg_idx_t'(i);
            #0.1;
            compared++;
            if (data_out !== 8'h00) begin
                mismatched++;
                $display("FAIL async_reset_sweep R%0d: got %h required %h", i, data_out, 8'h00);
            end
        end
    endtask

    task automatic test_overwrite;
        do_write(R1, 8'h11);
        do_write(R3, 8'h33);
        do_write(R2, 8'h01);
        compared++;
        if (data_out !== 8'h01) begin
            mismatched++;
            $display("FAIL overwrite_first: got %h required %h", data_out, 8'h01);
        end
        do_write(R2, 8'h80);
        @(negedge clk);
        en = 1'b0;
        reg_sel = R2;
        #1;
        compared++;
        if (data_out !== 8'h80) begin
            mismatched++;
            $display("FAIL overwrite_R2: got %h required %h", data_out, 8'h80);
        end
        reg_sel = R1;
        #1;
        compared++;
        if (data_out !== 8'h11) begin
            mismatched++;
            $display("FAIL overwrite_R1: got %h required %h", data_out, 8'h11);
        end
        reg_sel = R3;
        #1;
        compared++;
        if (data_out !== 8'h33) begin
            mismatched++;
            $display("FAIL overwrite_R3: got %h required %h", data_out, 8'h33);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        data_in    = 8'h00;
        reg_sel    = R0;
        test_reset();
        test_basic_writes();
        test_write_gating();
        test_no_bypass();
        test_async_reset();
        test_overwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_bank
